// File: rtl/alu_pkg.sv
// Shared types and constants for the signed arithmetic unit.
package alu_pkg;

    // Default operand width; results are twice this wide.
    localparam int ALU_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_DIV = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MUL = 2'd3
    } alu_op_t;

endpackage : alu_pkg

// File: rtl/alu.sv
// Signed add/sub/mul/div unit with one registered output stage.
// Operands are sign-extended to 2N bits first, so add, subtract, multiply
// and the single divide overflow case (-2^(N-1) / -1) all fit the result.
module alu
    import alu_pkg::*;
#(
    parameter int N = ALU_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [N-1:0]   in1,
    input  logic signed [N-1:0]   in2,
    input  logic [1:0]            op,
    input  logic                  invalid_data,
    output logic signed [2*N-1:0] out,
    output logic                  zero,
    output logic                  error
);

    localparam int W = 2 * N;

    alu_op_t             op_sel;
    logic signed [W-1:0] a_ext;
    logic signed [W-1:0] b_ext;
    logic signed [W-1:0] div_den;
    logic                div_by_zero;
    logic                fault;
    logic signed [W-1:0] result_raw;
    logic signed [W-1:0] out_next;
    logic                zero_next;
    logic                error_next;

    assign op_sel = alu_op_t'(op);
    assign a_ext  = {{N{in1[N-1]}}, in1};
    assign b_ext  = {{N{in2[N-1]}}, in2};

    // A zero divisor is swapped for 1 so the divider never sees 0; the
    // quotient is discarded in that case by the fault override below.
    assign div_by_zero = (op_sel == OP_DIV) && (in2 == '0);
    assign div_den     = div_by_zero ? W'(1) : b_ext;

    // Raw arithmetic result selected by opcode.
    always_comb begin
        result_raw = '0;
        case (op_sel)
            OP_DIV:  result_raw = a_ext / div_den;
            OP_ADD:  result_raw = a_ext + b_ext;
            OP_SUB:  result_raw = a_ext - b_ext;
            OP_MUL:  result_raw = a_ext * b_ext;
            default: result_raw = '0;
        endcase
    end

    // Invalid operands and divide-by-zero force a zeroed result with error
    // set; zero is only reported for a genuine result, so flags never overlap.
    always_comb begin
        fault      = invalid_data | div_by_zero;
        out_next   = fault ? '0 : result_raw;
        zero_next  = !fault && (result_raw == '0);
        error_next = fault;
    end

    // Output register bank; reset clears result and both flags at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            zero  <= 1'b0;
            error <= 1'b0;
        end else begin
            out   <= out_next;
            zero  <= zero_next;
            error <= error_next;
        end
    end

endmodule : alu

// File: tb/tb_alu.sv
// Directed-vector bench for the signed arithmetic unit at N = 8.
module tb_alu;
    import alu_pkg::*;

    localparam int N = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic signed [N-1:0]   in1 = '0;
    logic signed [N-1:0]   in2 = '0;
    logic [1:0]            op = 2'd1;
    logic                  invalid_data = 1'b0;
    logic signed [2*N-1:0] out;
    logic                  zero;
    logic                  error;

    int n_vec = 0;
    int n_err = 0;

    alu #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in1          (in1),
        .in2          (in2),
        .op           (op),
        .invalid_data (invalid_data),
        .out          (out),
        .zero         (zero),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        alu_op_t            o;
        logic               inv;
        logic signed [15:0] e_out;
        logic               e_zero;
        logic               e_err;
    } vec_t;

    // Drive one operation at the falling edge, then sample 1 after the rising edge.
    task automatic drive(input vec_t v);
        @(negedge clk);
        in1          = v.a;
        in2          = v.b;
        op           = v.o;
        invalid_data = v.inv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v;
        @(posedge clk);
        #1;
        n_vec++;
        if (out !== 16'sd0 || zero !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got out=%0d zero=%b error=%b, want out=0 zero=0 error=0", out, zero, error);
        end
        @(negedge clk);
        rst = 1'b0;
        v = '{8'sd3, 8'sd4, OP_MUL, 1'b0, 16'sd12, 1'b0, 1'b0};
        drive(v);
        n_vec++;
        if (out !== 16'sd12 || zero !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL first_after_reset: got out=%0d zero=%b error=%b, want out=12 zero=0 error=0", out, zero, error);
        end
    endtask

    task automatic test_add();
        vec_t t[5];
        t[0] = '{8'sd15,  8'sd15,  OP_ADD, 1'b0, 16'sd30,   1'b0, 1'b0};
        t[1] = '{-8'sd1,  -8'sd1,  OP_ADD, 1'b0, -16'sd2,   1'b0, 1'b0};
        t[2] = '{8'sd127, 8'sd127, OP_ADD, 1'b0, 16'sd254,  1'b0, 1'b0};
        t[3] = '{-8'sd128,-8'sd128,OP_ADD, 1'b0, -16'sd256, 1'b0, 1'b0};
        t[4] = '{8'sd5,   -8'sd5,  OP_ADD, 1'b0, 16'sd0,    1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(t[i]);
            n_vec++;
            if (out !== t[i].e_out || zero !== t[i].e_zero || error !== t[i].e_err) begin
                n_err++;
                $display("FAIL add[%0d]: got out=%0d zero=%b error=%b, want out=%0d zero=%b error=%b",
                         i, out, zero, error, t[i].e_out, t[i].e_zero, t[i].e_err);
            end
        end
    endtask

    task automatic test_sub();
        vec_t t[4];
        t[0] = '{8'sd10,   8'sd5,   OP_SUB, 1'b0, 16'sd5,    1'b0, 1'b0};
        t[1] = '{8'sd30,   8'sd60,  OP_SUB, 1'b0, -16'sd30,  1'b0, 1'b0};
        t[2] = '{-8'sd1,   -8'sd1,  OP_SUB, 1'b0, 16'sd0,    1'b1, 1'b0};
        t[3] = '{-8'sd128, 8'sd127, OP_SUB, 1'b0, -16'sd255, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(t[i]);
            n_vec++;
            if (out !== t[i].e_out || zero !== t[i].e_zero || error !== t[i].e_err) begin
                n_err++;
                $display("FAIL sub[%0d]: got out=%0d zero=%b error=%b, want out=%0d zero=%b error=%b",
                         i, out, zero, error, t[i].e_out, t[i].e_zero, t[i].e_err);
            end
        end
    endtask

    task automatic test_mul();
        vec_t t[5];
        t[0] = '{-8'sd1,   -8'sd1,   OP_MUL, 1'b0, 16'sd1,      1'b0, 1'b0};
        t[1] = '{8'sd10,   -8'sd10,  OP_MUL, 1'b0, -16'sd100,   1'b0, 1'b0};
        t[2] = '{-8'sd128, -8'sd128, OP_MUL, 1'b0, 16'sd16384,  1'b0, 1'b0};
        t[3] = '{8'sd0,    8'sd77,   OP_MUL, 1'b0, 16'sd0,      1'b1, 1'b0};
        t[4] = '{8'sd127,  -8'sd128, OP_MUL, 1'b0, -16'sd16256, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(t[i]);
            n_vec++;
            if (out !== t[i].e_out || zero !== t[i].e_zero || error !== t[i].e_err) begin
                n_err++;
                $display("FAIL mul[%0d]: got out=%0d zero=%b error=%b, want out=%0d zero=%b error=%b",
                         i, out, zero, error, t[i].e_out, t[i].e_zero, t[i].e_err);
            end
        end
    endtask

    task automatic test_div();
        vec_t t[8];
        t[0] = '{8'sd25,   -8'sd5, OP_DIV, 1'b0, -16'sd5,  1'b0, 1'b0};
        t[1] = '{8'sd13,   8'sd3,  OP_DIV, 1'b0, 16'sd4,   1'b0, 1'b0};
        t[2] = '{-8'sd13,  8'sd3,  OP_DIV, 1'b0, -16'sd4,  1'b0, 1'b0};
        t[3] = '{-8'sd128, -8'sd1, OP_DIV, 1'b0, 16'sd128, 1'b0, 1'b0};
        t[4] = '{8'sd10,   8'sd0,  OP_DIV, 1'b0, 16'sd0,   1'b0, 1'b1};
        t[5] = '{8'sd0,    8'sd5,  OP_DIV, 1'b0, 16'sd0,   1'b1, 1'b0};
        t[6] = '{8'sd7,    -8'sd2, OP_DIV, 1'b0, -16'sd3,  1'b0, 1'b0};
        t[7] = '{8'sd0,    8'sd0,  OP_DIV, 1'b0, 16'sd0,   1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(t[i]);
            n_vec++;
            if (out !== t[i].e_out || zero !== t[i].e_zero || error !== t[i].e_err) begin
                n_err++;
                $display("FAIL div[%0d]: got out=%0d zero=%b error=%b, want out=%0d zero=%b error=%b",
                         i, out, zero, error, t[i].e_out, t[i].e_zero, t[i].e_err);
            end
        end
    endtask

    task automatic test_invalid();
        vec_t t[5];
        t[0] = '{8'sd10, -8'sd10, OP_DIV, 1'b1, 16'sd0,  1'b0, 1'b1};
        t[1] = '{8'sd10, -8'sd10, OP_DIV, 1'b0, -16'sd1, 1'b0, 1'b0};
        t[2] = '{8'sd0,  8'sd0,   OP_ADD, 1'b1, 16'sd0,  1'b0, 1'b1};
        t[3] = '{8'sd9,  8'sd9,   OP_MUL, 1'b1, 16'sd0,  1'b0, 1'b1};
        t[4] = '{8'sd9,  8'sd9,   OP_MUL, 1'b0, 16'sd81, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(t[i]);
            n_vec++;
            if (out !== t[i].e_out || zero !== t[i].e_zero || error !== t[i].e_err) begin
                n_err++;
                $display("FAIL invalid[%0d]: got out=%0d zero=%b error=%b, want out=%0d zero=%b error=%b",
                         i, out, zero, error, t[i].e_out, t[i].e_zero, t[i].e_err);
            end
        end
    endtask

    // Outputs must hold while inputs stay put, across further clock edges.
    task automatic test_hold();
        vec_t v;
        v = '{-8'sd7, 8'sd6, OP_MUL, 1'b0, -16'sd42, 1'b0, 1'b0};
        drive(v);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out !== -16'sd42 || zero !== 1'b0 || error !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got out=%0d zero=%b error=%b, want out=-42 zero=0 error=0", i, out, zero, error);
            end
        end
    endtask

    // Back-to-back operations, then reset asserted between edges.
    task automatic test_back_to_back_reset();
        vec_t pre[2];
        vec_t post;
        pre[0] = '{8'sd100, 8'sd27, OP_ADD, 1'b0, 16'sd127, 1'b0, 1'b0};
        pre[1] = '{8'sd4,   8'sd0,  OP_DIV, 1'b0, 16'sd0,   1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            drive(pre[i]);
            n_vec++;
            if (out !== pre[i].e_out || error !== pre[i].e_err) begin
                n_err++;
                $display("FAIL b2b_pre[%0d]: got out=%0d error=%b, want out=%0d error=%b",
                         i, out, error, pre[i].e_out, pre[i].e_err);
            end
            #2;
            rst = 1'b1;
            #1;
            n_vec++;
            if (out !== 16'sd0 || zero !== 1'b0 || error !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset[%0d]: got out=%0d zero=%b error=%b, want out=0 zero=0 error=0",
                         i, out, zero, error);
            end
            in1 = 8'sd50;
            in2 = 8'sd2;
            op  = OP_ADD;
            @(posedge clk);
            #1;
            n_vec++;
            if (out !== 16'sd0 || zero !== 1'b0 || error !== 1'b0) begin
                n_err++;
                $display("FAIL reset_across_edge[%0d]: got out=%0d zero=%b error=%b, want out=0 zero=0 error=0",
                         i, out, zero, error);
            end
            @(negedge clk);
            rst = 1'b0;
        end
        post = '{8'sd50, 8'sd2, OP_SUB, 1'b0, 16'sd48, 1'b0, 1'b0};
        drive(post);
        n_vec++;
        if (out !== 16'sd48 || zero !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL after_release: got out=%0d zero=%b error=%b, want out=48 zero=0 error=0", out, zero, error);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_invalid();
        test_hold();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu
